// File: rtl/apb_gpio_lock_gate.sv
// rtl/apb_gpio_lock_gate.sv - APB write gate for GPIO output channels with per-channel locks and a key-sequence unlock.
module apb_gpio_lock_gate #(
  parameter int                DATA_W     = 32,
  parameter int                N_CH       = 4,
  parameter int                ADDR_W     = 8,
  parameter int                CNT_W      = 16,
  parameter logic [N_CH-1:0]   LOCK_RESET = {N_CH{1'b1}},
  parameter logic [DATA_W-1:0] DATA_RESET = '0,
  parameter logic [31:0]       KEY1       = 32'h5EC0_0DE1,
  parameter logic [31:0]       KEY2       = 32'h5EC0_0DE2
) (
  input  logic                   HCLK,
  input  logic                   HRESET,
  input  logic                   PSEL,
  input  logic                   PENABLE,
  input  logic                   PWRITE,
  input  logic [ADDR_W-1:0]      PADDR,
  input  logic [DATA_W-1:0]      PWDATA,
  output logic [DATA_W-1:0]      PRDATA,
  output logic                   PREADY,
  output logic                   PSLVERR,
  output logic [N_CH*DATA_W-1:0] gpio_out,
  output logic [N_CH-1:0]        lock_o
);

  localparam int WA_W = ADDR_W - 2;
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_KEY1_OK = 2'd1,
    ST_ARMED   = 2'd2
  } state_e;

  state_e                         state_q, state_d;
  logic [N_CH-1:0]                lock_q, lock_d;
  logic [N_CH-1:0][DATA_W-1:0]    data_q, data_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic                           glock_q, glock_d;

  logic [WA_W-1:0] word;
  logic [CH_W-1:0] ch_idx;
  logic            sel_lock, sel_key, sel_status, sel_data, mapped;
  logic            access, wr_acc, rd_acc;
  logic [DATA_W-1:0] status_rd;
  logic [DATA_W-1:0] prdata_c;
  logic            pslverr_c;
  logic            unused_addr_lsb;

  assign unused_addr_lsb = ^PADDR[1:0];

  assign word       = PADDR[ADDR_W-1:2];
  assign ch_idx     = CH_W'(word - WA_W'(4));
  assign sel_lock   = (word == WA_W'(0));
  assign sel_key    = (word == WA_W'(1));
  assign sel_status = (word == WA_W'(2));
  assign sel_data   = (word >= WA_W'(4)) && (word < WA_W'(4 + N_CH));
  assign mapped     = sel_lock | sel_key | sel_status | sel_data;

  assign access = PSEL & PENABLE;
  assign wr_acc = access & PWRITE;
  assign rd_acc = access & ~PWRITE;

  always_comb begin
    status_rd            = '0;
    status_rd[CNT_W-1:0] = cnt_q;
    status_rd[17:16]     = state_q;
    status_rd[18]        = glock_q;
  end

  always_comb begin
    prdata_c  = '0;
    pslverr_c = 1'b0;
    if (access) begin
      if (!mapped) begin
        pslverr_c = 1'b1;
      end else if (PWRITE && sel_data && lock_q[ch_idx]) begin
        pslverr_c = 1'b1;
      end else if (PWRITE && sel_key && glock_q) begin
        pslverr_c = 1'b1;
      end
    end
    if (rd_acc) begin
      if (sel_lock) begin
        prdata_c = DATA_W'(lock_q);
      end else if (sel_status) begin
        prdata_c = status_rd;
      end else if (sel_data) begin
        prdata_c = data_q[ch_idx];
      end
    end
  end

  // Register updates: only completed accesses change state.
  always_comb begin
    lock_d  = lock_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    glock_d = glock_q;
    if (wr_acc) begin
      if (sel_lock) begin
        if (state_q == ST_ARMED) begin
          lock_d = lock_q & ~PWDATA[N_CH-1:0];
        end else begin
          lock_d = lock_q | PWDATA[N_CH-1:0];
        end
      end
      if (sel_status) begin
        if (PWDATA[31]) begin
          glock_d = 1'b1;
        end
        if (PWDATA[30]) begin
          cnt_d = '0;
        end
      end
      if (sel_data) begin
        if (lock_q[ch_idx]) begin
          if (cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          data_d[ch_idx] = PWDATA;
        end
      end
    end
  end

  // Unlock FSM: any access that does not advance the key sequence falls back to IDLE.
  always_comb begin
    state_d = state_q;
    if (access) begin
      state_d = ST_IDLE;
      case (state_q)
        ST_IDLE: begin
          if (wr_acc && sel_key && (PWDATA == DATA_W'(KEY1))) begin
            state_d = ST_KEY1_OK;
          end
        end
        ST_KEY1_OK: begin
          if (wr_acc && sel_key && (PWDATA == DATA_W'(KEY2))) begin
            state_d = ST_ARMED;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    // Global lock (including one being set right now) pins the FSM in IDLE.
    if (glock_d) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q <= ST_IDLE;
      lock_q  <= LOCK_RESET;
      data_q  <= {N_CH{DATA_RESET}};
      cnt_q   <= '0;
      glock_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      glock_q <= glock_d;
    end
  end

  assign PRDATA   = prdata_c;
  assign PSLVERR  = pslverr_c;
  assign PREADY   = 1'b1;
  assign gpio_out = data_q;
  assign lock_o   = lock_q;

endmodule
